// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: opcodes, FSM states, ALU ops and datapath select encodings for the multi-cycle RV32I controller
package riscv_ctrl_pkg;
  localparam logic [6:0] OPC_R      = 7'b0110011;
  localparam logic [6:0] OPC_I      = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP} state_e;
  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
  } alu_op_e;
  typedef enum logic [3:0] {
    C_R, C_I, C_LOAD, C_STORE, C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC, C_BAD
  } op_class_e;
  localparam logic [1:0] PC_PLUS4 = 2'd0;
  localparam logic [1:0] PC_IMM   = 2'd1;
  localparam logic [1:0] PC_ALU   = 2'd2;
  localparam logic [1:0] WB_ALU   = 2'd0;
  localparam logic [1:0] WB_MEM   = 2'd1;
  localparam logic [1:0] WB_PC4   = 2'd2;
  localparam logic [1:0] WB_IMM   = 2'd3;
  localparam logic A_RS1 = 1'b0;
  localparam logic A_PC  = 1'b1;
  localparam logic B_RS2 = 1'b0;
  localparam logic B_IMM = 1'b1;
  function automatic op_class_e op_class(input logic [6:0] opcode);
    case (opcode)
      OPC_R:      op_class = C_R;
      OPC_I:      op_class = C_I;
      OPC_LOAD:   op_class = C_LOAD;
      OPC_STORE:  op_class = C_STORE;
      OPC_BRANCH: op_class = C_BRANCH;
      OPC_JAL:    op_class = C_JAL;
      OPC_JALR:   op_class = C_JALR;
      OPC_LUI:    op_class = C_LUI;
      OPC_AUIPC:  op_class = C_AUIPC;
      default:    op_class = C_BAD;
    endcase
  endfunction
  function automatic logic legal(input op_class_e cls, input logic [2:0] funct3);
    legal = cls == C_BAD    ? 1'b0 :
            cls == C_BRANCH ? funct3[2:1] != 2'b01 :
            cls == C_LOAD   ? !(funct3 == 3'b011 || funct3[2:1] == 2'b11) :
            cls == C_STORE  ? funct3 <= 3'd2 :
            cls == C_JALR   ? funct3 == 3'd0 : 1'b1;
  endfunction
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps instruction class, funct3 and funct7_5 to the ALU operation
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  op_class_e  cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output alu_op_e    alu_ctrl
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    if (cls == C_R || cls == C_I)
      case (funct3)
        3'b000: alu_ctrl = (cls == C_R && funct7_5) ? ALU_SUB : ALU_ADD;
        3'b001: alu_ctrl = ALU_SLL;
        3'b010: alu_ctrl = ALU_SLT;
        3'b011: alu_ctrl = ALU_SLTU;
        3'b100: alu_ctrl = ALU_XOR;
        3'b101: alu_ctrl = funct7_5 ? ALU_SRA : ALU_SRL;
        3'b110: alu_ctrl = ALU_OR;
        3'b111: alu_ctrl = ALU_AND;
      endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: FETCH/DECODE/EXEC/MEM/WB sequencer for the multi-cycle RV32I datapath,
// with sticky illegal-instruction trap and retired-instruction counter
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic        funct7_5,
  input  logic        alu_zero,
  input  logic        alu_lt,
  input  logic        alu_ltu,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output alu_op_e     alu_ctrl,
  output logic        illegal,
  output logic [31:0] instret
);
  state_e      state_q, state_d;
  logic        illegal_q, illegal_d;
  logic [31:0] instret_q, instret_d;
  op_class_e   cls;
  alu_op_e     alu_dec;
  logic        taken, retire;
  assign cls = op_class(opcode);
  assign taken = funct3[0] ^ (funct3[2] ? (funct3[1] ? alu_ltu : alu_lt) : alu_zero);
  alu_decoder u_alu_decoder (
    .cls      (cls),
    .funct3   (funct3),
    .funct7_5 (funct7_5),
    .alu_ctrl (alu_dec)
  );
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = PC_PLUS4;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_a_sel = A_RS1;
    alu_b_sel = B_RS2;
    alu_ctrl  = ALU_ADD;
    // ALU setup is held through MEM and WB so address/result stay valid on the combinational datapath
    if (state_q == S_EXEC || state_q == S_MEM || state_q == S_WB) begin
      alu_ctrl  = alu_dec;
      alu_a_sel = cls == C_AUIPC ? A_PC : A_RS1;
      alu_b_sel = (cls inside {C_I, C_LOAD, C_STORE, C_JALR, C_AUIPC}) ? B_IMM : B_RS2;
    end
    case (state_q)
      S_FETCH: begin
        mem_req = rst_n;
        ir_we   = rst_n & mem_ready;
        state_d = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: state_d = legal(cls, funct3) ? S_EXEC : S_TRAP;
      S_EXEC: begin
        pc_we   = cls == C_BRANCH;
        pc_src  = (cls == C_BRANCH && taken) ? PC_IMM : PC_PLUS4;
        retire  = cls == C_BRANCH;
        state_d = cls == C_BRANCH ? S_FETCH : (cls == C_LOAD || cls == C_STORE) ? S_MEM : S_WB;
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = cls == C_STORE;
        pc_we   = mem_ready && cls == C_STORE;
        retire  = mem_ready && cls == C_STORE;
        state_d = !mem_ready ? S_MEM : cls == C_STORE ? S_FETCH : S_WB;
      end
      S_WB: begin
        reg_we  = 1'b1;
        pc_we   = 1'b1;
        retire  = 1'b1;
        wb_sel  = cls == C_LOAD ? WB_MEM : (cls == C_JAL || cls == C_JALR) ? WB_PC4 :
                  cls == C_LUI ? WB_IMM : WB_ALU;
        pc_src  = cls == C_JAL ? PC_IMM : cls == C_JALR ? PC_ALU : PC_PLUS4;
        state_d = S_FETCH;
      end
      default: state_d = S_TRAP;
    endcase
    illegal_d = illegal_q | (state_q == S_DECODE && !legal(cls, funct3));
    instret_d = instret_q + {31'b0, retire};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q   <= S_FETCH;
      illegal_q <= 1'b0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      instret_q <= instret_d;
    end
  assign illegal = illegal_q;
  assign instret = instret_q;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: randomized instruction stream against a spec-level timing model,
// scoreboard-checked per cycle, plus directed trap, mid-transaction reset and counter-wrap cases
module tb_multicycle_control_unit;
  import riscv_ctrl_pkg::*;
  logic clk = 1'b0, rst_n = 1'b1;
  logic [6:0] opcode = '0;
  logic [2:0] funct3 = '0;
  logic funct7_5 = 1'b0, alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0, mem_ready = 1'b0;
  logic mem_req, mem_we, ir_we, pc_we, reg_we, alu_a_sel, alu_b_sel, illegal;
  logic [1:0] pc_src, wb_sel;
  alu_op_e alu_ctrl;
  logic [31:0] instret;

  always #5 clk = ~clk;

  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel),
    .alu_ctrl(alu_ctrl), .illegal(illegal), .instret(instret)
  );

  // class index: 0 R, 1 I-ALU, 2 LOAD, 3 STORE, 4 BRANCH, 5 JAL, 6 JALR, 7 LUI, 8 AUIPC
  localparam logic [6:0] OPS [9] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6f, 7'h67, 7'h37, 7'h17};

  typedef struct {
    int fw, mw, cycles, exec_cyc;
    bit wb, store, memop, chk_alu, a_sel, b_sel;
    logic [1:0] pc_src, wb_sel;
    alu_op_e alu;
    logic [31:0] icount;
  } exp_t;

  exp_t q[$];
  exp_t me;
  int tests = 0, fails = 0, cyc = 0;
  bit mon_en = 1'b0;
  logic [31:0] icount = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit legal_f3(input int k, input logic [2:0] f3);
    case (k)
      2: return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      3: return f3 < 3'd3;
      4: return f3 != 3'd2 && f3 != 3'd3;
      6: return f3 == 3'd0;
      default: return 1'b1;
    endcase
  endfunction

  function automatic bit is_legal_op(input logic [6:0] op);
    for (int i = 0; i < 9; i++) if (OPS[i] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit br_taken(input logic [2:0] f3, input logic z, input logic lt, input logic ltu);
    case (f3)
      3'd0: return z;
      3'd1: return !z;
      3'd4: return lt;
      3'd5: return !lt;
      3'd6: return ltu;
      3'd7: return !ltu;
      default: return 1'b0;
    endcase
  endfunction

  function automatic alu_op_e exp_alu(input int k, input logic [2:0] f3, input logic f7);
    alu_op_e base [8] = '{ALU_ADD, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_OR, ALU_AND};
    if (k > 1) return ALU_ADD;
    if (f3 == 3'd0 && k == 0 && f7) return ALU_SUB;
    if (f3 == 3'd5 && f7) return ALU_SRA;
    return base[f3];
  endfunction

  // fw/mw: wait cycles before mem_ready on the fetch and on the data access
  task automatic run_instr(input int k, input logic [2:0] f3, input logic f7, input logic [2:0] fl,
                           input int fw, input int mw);
    exp_t e;
    int cnt, guard;
    bit done, hs;
    e.fw       = fw;
    e.memop    = (k == 2 || k == 3);
    e.store    = (k == 3);
    e.mw       = e.memop ? mw : 0;
    e.cycles   = (k == 4 ? 3 : k == 2 ? 5 : 4) + fw + e.mw;
    e.exec_cyc = fw + 3;
    e.wb       = !(k == 3 || k == 4);
    e.wb_sel   = k == 2 ? 2'd1 : (k == 5 || k == 6) ? 2'd2 : k == 7 ? 2'd3 : 2'd0;
    e.pc_src   = k == 4 ? {1'b0, br_taken(f3, fl[2], fl[1], fl[0])} : k == 5 ? 2'd1 : k == 6 ? 2'd2 : 2'd0;
    e.chk_alu  = !(k == 4 || k == 5 || k == 7);
    e.a_sel    = (k == 8);
    e.b_sel    = (k == 1 || k == 2 || k == 3 || k == 6 || k == 8);
    e.alu      = exp_alu(k, f3, f7);
    e.icount   = icount;
    icount++;
    q.push_back(e);
    opcode = OPS[k];
    funct3 = f3;
    funct7_5 = f7;
    {alu_zero, alu_lt, alu_ltu} = fl;
    cnt = fw;
    done = 1'b0;
    guard = 0;
    while (!done && guard < 40) begin
      mem_ready = mem_req ? (cnt == 0) : 1'($urandom_range(0, 1));
      #1;
      done = pc_we;
      hs = mem_req && mem_ready;
      if (mem_req && !mem_ready) cnt--;
      if (hs) cnt = mw;
      @(negedge clk);
      guard++;
    end
    if (!done) begin
      tests++;
      fails++;
      $display("FAIL timeout: instruction class %0d never completed", k);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n || !mon_en) cyc = 0;
    else if (q.size() > 0) begin
      me = q[0];
      cyc++;
      chk("mem_req", 32'(mem_req), 32'(cyc <= me.fw + 1 || (me.memop && cyc >= me.fw + 4 && cyc <= me.fw + 4 + me.mw)));
      chk("mem_we", 32'(mem_we), 32'(me.store && cyc >= me.fw + 4));
      chk("ir_we", 32'(ir_we), 32'(cyc == me.fw + 1));
      chk("pc_we", 32'(pc_we), 32'(cyc == me.cycles));
      chk("reg_we", 32'(reg_we), 32'(me.wb && cyc == me.cycles));
      if (cyc == me.exec_cyc && me.chk_alu) begin
        chk("alu_ctrl", 32'(alu_ctrl), 32'(me.alu));
        chk("alu_a_sel", 32'(alu_a_sel), 32'(me.a_sel));
        chk("alu_b_sel", 32'(alu_b_sel), 32'(me.b_sel));
      end
      if (cyc == me.cycles || pc_we) begin
        chk("pc_src", 32'(pc_src), 32'(me.pc_src));
        if (me.wb) chk("wb_sel", 32'(wb_sel), 32'(me.wb_sel));
        chk("instret", instret, me.icount);
        void'(q.pop_front());
        cyc = 0;
      end
    end
  end

  task automatic check_reset();
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_enables", 32'({mem_we, ir_we, pc_we, reg_we}), 0);
    chk("rst_selects", 32'({pc_src, wb_sel, alu_a_sel, alu_b_sel}), 0);
    chk("rst_alu_ctrl", 32'(alu_ctrl), 32'(ALU_ADD));
    chk("rst_illegal", 32'(illegal), 0);
    chk("rst_instret", instret, 0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    mem_ready = 1'b1;
    #1;
    check_reset();
    mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    icount = '0;
    @(negedge clk);
  endtask

  task automatic trap_test(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] exp_ir);
    opcode = op;
    funct3 = f3;
    funct7_5 = 1'($urandom_range(0, 1));
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'($urandom_range(0, 1));
    #1 chk("trap_decode_illegal", 32'(illegal), 0);
    @(negedge clk);
    #1 chk("trap_cycle3_illegal", 32'(illegal), 1);
    repeat (20) begin
      mem_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      #1;
      chk("trap_mem_req", 32'(mem_req), 0);
      chk("trap_enables", 32'({mem_we, ir_we, pc_we, reg_we}), 0);
      chk("trap_sticky", 32'(illegal), 1);
      chk("trap_instret", instret, exp_ir);
    end
  endtask

  initial begin
    int k, fw, mw, guard;
    logic [2:0] f3;
    logic [6:0] op;
    #3;
    do_reset();
    mon_en = 1'b1;
    run_instr(1, 3'd0, 1'b0, 3'b000, 0, 0);
    run_instr(2, 3'd2, 1'b0, 3'b000, 0, 3);
    run_instr(4, 3'd0, 1'b0, 3'b100, 0, 0);
    run_instr(4, 3'd0, 1'b0, 3'b011, 0, 0);
    run_instr(3, 3'd2, 1'b0, 3'b000, 0, 0);
    for (int n = 0; n < 250; n++) begin
      k = $urandom_range(0, 8);
      do f3 = 3'($urandom_range(0, 7)); while (!legal_f3(k, f3));
      fw = $urandom_range(0, 2);
      mw = $urandom_range(0, 3);
      run_instr(k, f3, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), fw, mw);
    end
    mon_en = 1'b0;
    chk("queue_drained", 32'(q.size()), 0);
    trap_test(7'h7f, 3'd0, icount);
    do_reset(); trap_test(7'h00, 3'd0, 0);
    do_reset(); trap_test(OPS[4], 3'd2, 0);
    do_reset(); trap_test(OPS[4], 3'd3, 0);
    do_reset(); trap_test(OPS[2], 3'd3, 0);
    do_reset(); trap_test(OPS[2], 3'd6, 0);
    do_reset(); trap_test(OPS[2], 3'd7, 0);
    do_reset(); trap_test(OPS[3], 3'd3, 0);
    do_reset(); trap_test(OPS[3], 3'd7, 0);
    do_reset(); trap_test(OPS[6], 3'd1, 0);
    do_reset(); trap_test(OPS[6], 3'd5, 0);
    do op = 7'($urandom); while (is_legal_op(op));
    do_reset(); trap_test(op, 3'($urandom_range(0, 7)), 0);
    do_reset();
    mon_en = 1'b1;
    run_instr(1, 3'd4, 1'b0, 3'b000, 0, 0);
    mon_en = 1'b0;
    opcode = OPS[3];
    funct3 = 3'd2;
    mem_ready = 1'b1;
    @(negedge clk);
    mem_ready = 1'b0;
    guard = 0;
    while (!(mem_req && mem_we) && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk("sw_reached_mem", 32'(mem_req && mem_we), 1);
    chk("sw_instret_pre", instret, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("sw_rst_mem_req", 32'(mem_req), 0);
    chk("sw_rst_mem_we", 32'(mem_we), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    #1;
    chk("sw_refetch_mem_req", 32'({mem_req, mem_we}), 32'(2'b10));
    chk("sw_instret_cleared", instret, 0);
    chk("sw_illegal_cleared", 32'(illegal), 0);
    do_reset();
    force dut.instret_q = 32'hFFFF_FFFF;
    #1 release dut.instret_q;
    @(negedge clk);
    icount = 32'hFFFF_FFFF;
    mon_en = 1'b1;
    run_instr(5, 3'd0, 1'b0, 3'b000, 0, 0);
    mon_en = 1'b0;
    #1 chk("instret_wrap", instret, 0);
    chk("queue_empty_end", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
